// File: rtl/stereo_band_scheduler.sv
// Band buffer and column sequencer feeding the per-pixel disparity engine.
// Raster-order L/R pixels fill a WIN-row circular band; each window column
// is then run through the engine (clear, start, wait done) and its disparity
// is forwarded downstream with a valid/ready handshake.
module stereo_band_scheduler #(
    parameter int WIN       = 3,
    parameter int DATA_SIZE = 8,
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 48,
    parameter int MAX_DISP  = 16,
    parameter int DISP_BITS = 4,
    parameter int IMG_W_ARR = 6,
    parameter int ROW_BITS  = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    input  logic [DATA_SIZE-1:0]             pix_L,
    input  logic [DATA_SIZE-1:0]             pix_R,
    output logic [DATA_SIZE*IMG_W*WIN-1:0]   band_L,
    output logic [DATA_SIZE*IMG_W*WIN-1:0]   band_R,
    output logic [IMG_W_ARR-1:0]             col_index,
    output logic                             core_clr,
    output logic                             core_start,
    input  logic [DISP_BITS-1:0]             core_disp,
    input  logic                             core_done,
    output logic                             disp_valid,
    output logic [DISP_BITS-1:0]             disp_data,
    input  logic                             disp_ready,
    output logic                             frame_done
);

    localparam int NCOL   = IMG_W - WIN - MAX_DISP + 1;
    localparam int NBAND  = IMG_H - WIN + 1;
    localparam int SLOT_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int RL_W   = $clog2(WIN + 1);

    localparam logic [IMG_W_ARR-1:0] LAST_COL   = IMG_W_ARR'(NCOL - 1);
    localparam logic [IMG_W_ARR-1:0] COL_MAX    = IMG_W_ARR'(IMG_W - 1);
    localparam logic [ROW_BITS-1:0]  LAST_BAND  = ROW_BITS'(NBAND - 1);
    localparam logic [SLOT_W-1:0]    LAST_SLOT  = SLOT_W'(WIN - 1);
    localparam logic [SLOT_W:0]      WIN_S      = (SLOT_W + 1)'(WIN);
    localparam logic [RL_W-1:0]      FIRST_NEED = RL_W'(WIN);
    localparam logic [RL_W-1:0]      LATER_NEED = RL_W'(1);

    typedef enum logic [2:0] {
        S_FILL,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_EMIT,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t state, state_next;

    logic [DATA_SIZE-1:0] mem_L [WIN][IMG_W];
    logic [DATA_SIZE-1:0] mem_R [WIN][IMG_W];

    logic [IMG_W_ARR-1:0] wr_col;
    logic [SLOT_W-1:0]    wr_slot;
    logic [RL_W-1:0]      rows_loaded;
    logic [ROW_BITS-1:0]  band_cnt;

    logic                 pix_xfer;
    logic                 row_end;
    logic                 band_ready;
    logic [RL_W-1:0]      rows_need;

    assign pix_xfer   = pix_valid && pix_ready;
    assign row_end    = pix_xfer && (wr_col == COL_MAX);
    assign rows_need  = (band_cnt == '0) ? FIRST_NEED : LATER_NEED;
    assign band_ready = row_end && ((rows_loaded + RL_W'(1)) == rows_need);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FILL;
        else     state <= state_next;
    end

    // Next-state decode and single-cycle control pulses
    always_comb begin
        state_next = state;
        pix_ready  = 1'b0;
        core_clr   = 1'b0;
        core_start = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_FILL: begin
                pix_ready = !rst;
                if (band_ready) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                core_clr   = 1'b1;
                state_next = S_START;
            end
            S_START: begin
                core_start = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) state_next = S_EMIT;
            end
            S_EMIT: begin
                if (disp_ready) state_next = (col_index == LAST_COL) ? S_ADVANCE : S_CLEAR;
            end
            S_ADVANCE: begin
                state_next = (band_cnt == LAST_BAND) ? S_FINISH : S_FILL;
            end
            S_FINISH: begin
                frame_done = 1'b1;
                state_next = S_FILL;
            end
            default: state_next = S_FILL;
        endcase
    end

    // Counters, column pointer and output disparity register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_col      <= '0;
            wr_slot     <= '0;
            rows_loaded <= '0;
            band_cnt    <= '0;
            col_index   <= '0;
            disp_valid  <= 1'b0;
            disp_data   <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (pix_xfer) begin
                        if (wr_col == COL_MAX) begin
                            wr_col  <= '0;
                            wr_slot <= (wr_slot == LAST_SLOT) ? '0 : wr_slot + SLOT_W'(1);
                            if (band_ready) begin
                                rows_loaded <= '0;
                                col_index   <= '0;
                            end else begin
                                rows_loaded <= rows_loaded + RL_W'(1);
                            end
                        end else begin
                            wr_col <= wr_col + IMG_W_ARR'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (core_done) begin
                        disp_data  <= core_disp;
                        disp_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (disp_ready) begin
                        disp_valid <= 1'b0;
                        if (col_index != LAST_COL) col_index <= col_index + IMG_W_ARR'(1);
                    end
                end
                S_ADVANCE: begin
                    if (band_cnt != LAST_BAND) band_cnt <= band_cnt + ROW_BITS'(1);
                end
                S_FINISH: begin
                    wr_col      <= '0;
                    wr_slot     <= '0;
                    rows_loaded <= '0;
                    band_cnt    <= '0;
                    col_index   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Pixel storage, written only while filling; intentionally not reset
    always_ff @(posedge clk) begin
        if (pix_xfer) begin
            mem_L[wr_slot][wr_col] <= pix_L;
            mem_R[wr_slot][wr_col] <= pix_R;
        end
    end

    // Band row r maps to slot (oldest + r) mod WIN. The next slot to be
    // written is always the oldest one, so wr_slot doubles as the oldest pointer.
    for (genvar r = 0; r < WIN; r++) begin : g_row
        logic [SLOT_W:0]   slot_sum;
        logic [SLOT_W-1:0] slot;
        assign slot_sum = {1'b0, wr_slot} + (SLOT_W + 1)'(r);
        assign slot     = (slot_sum >= WIN_S) ? SLOT_W'(slot_sum - WIN_S) : SLOT_W'(slot_sum);
        for (genvar c = 0; c < IMG_W; c++) begin : g_col
            assign band_L[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = rst ? '0 : mem_L[slot][c];
            assign band_R[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = rst ? '0 : mem_R[slot][c];
        end
    end

endmodule

// File: tb/tb_stereo_band_scheduler.sv
// Randomized bench for stereo_band_scheduler with a stub disparity engine
// and a frame-level reference model (image array, band/column counters).
module tb_stereo_band_scheduler;

    localparam int WIN   = 3;
    localparam int DS    = 8;
    localparam int W     = 64;
    localparam int H     = 48;
    localparam int MD    = 16;
    localparam int DB    = 4;
    localparam int NCOL  = W - WIN - MD + 1;
    localparam int NBAND = H - WIN + 1;
    localparam int BW    = DS * W * WIN;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic          pix_ready;
    logic [DS-1:0] pix_L, pix_R;
    logic [BW-1:0] band_L, band_R;
    logic [5:0]    col_index;
    logic          core_clr, core_start;
    logic [DB-1:0] core_disp;
    logic          core_done;
    logic          disp_valid;
    logic [DB-1:0] disp_data;
    logic          disp_ready;
    logic          frame_done;

    stereo_band_scheduler #(
        .WIN(WIN), .DATA_SIZE(DS), .IMG_W(W), .IMG_H(H),
        .MAX_DISP(MD), .DISP_BITS(DB), .IMG_W_ARR(6), .ROW_BITS(6)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_L(pix_L), .pix_R(pix_R),
        .band_L(band_L), .band_R(band_R),
        .col_index(col_index),
        .core_clr(core_clr), .core_start(core_start),
        .core_disp(core_disp), .core_done(core_done),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [DS-1:0] img_L [H][W];
    logic [DS-1:0] img_R [H][W];
    int          feed_idx, model_band, model_col, skip, hs_frame, frames_done;
    bit          fin, col_mode, stop_hit;
    int          eng_cnt, rdy_pct;
    int          disp_q[$];
    bit          prev_valid, prev_x;
    logic [DB-1:0] prev_data;
    logic [5:0]  prev_col;
    int          n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic new_image();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img_L[r][c] = DS'($urandom);
                img_R[r][c] = DS'($urandom);
            end
    endtask

    function automatic int thr();
        return W * WIN + W * model_band;
    endfunction

    // one clock: sample and check at negedge, then drive after posedge
    task automatic step();
        bit clr_seen, pix_x, disp_x, exp_fd;
        int r, c;
        clr_seen = 0;
        @(negedge clk);
        if (!rst) begin
            if (skip > 0) check("pix_ready_gap", pix_ready, 0);
            else          check("pix_ready", pix_ready, feed_idx < thr());
            exp_fd = fin && (skip == 1);
            if (frame_done || exp_fd) begin
                check("frame_done", frame_done, exp_fd);
                if (exp_fd) begin
                    check("frame_count", hs_frame, NBAND * NCOL);
                    frames_done++;
                    feed_idx = 0; model_band = 0; model_col = 0;
                    hs_frame = 0; fin = 0;
                    new_image();
                end
            end
            if (skip > 0) skip--;
            if (prev_valid && !prev_x) begin
                check("hold_valid", disp_valid, 1);
                check("hold_data", disp_data, prev_data);
                check("hold_col", col_index, prev_col);
            end
            if (disp_valid) check("no_clr_in_emit", core_clr, 0);
            if (core_start) begin
                check("start_col", col_index, model_col);
                check("start_pix_count", feed_idx, thr());
                r = $urandom_range(0, WIN - 1);
                c = $urandom_range(0, W - 1);
                check("band_L", band_L[DS*(r*W+c) +: DS], img_L[model_band + r][c]);
                check("band_R", band_R[DS*(r*W+c) +: DS], img_R[model_band + r][c]);
                if (model_band == 1 && model_col == 5 && frames_done == 1) stop_hit = 1;
                eng_cnt = $urandom_range(1, 4);
            end
            clr_seen = core_clr;
            pix_x  = pix_valid && pix_ready;
            disp_x = disp_valid && disp_ready;
            if (pix_x) feed_idx++;
            if (disp_x) begin
                if (disp_q.size() == 0) check("disp_unexpected", 1, 0);
                else                    check("disp_data", disp_data, disp_q.pop_front());
                hs_frame++;
                model_col++;
                if (model_col == NCOL) begin
                    model_col = 0;
                    model_band++;
                    fin  = (model_band == NBAND);
                    skip = fin ? 2 : 1;
                end
            end
            prev_valid = disp_valid;
            prev_x     = disp_x;
            prev_data  = disp_data;
            prev_col   = col_index;
        end
        @(posedge clk);
        #1;
        if (clr_seen) core_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                core_disp = col_mode ? DB'(model_col) : DB'($urandom);
                disp_q.push_back(int'(core_disp));
                core_done = 1'b1;
            end
        end
        pix_valid = (feed_idx < W * H) && ($urandom_range(0, 9) < 8);
        if (feed_idx < W * H) begin
            pix_L = img_L[feed_idx / W][feed_idx % W];
            pix_R = img_R[feed_idx / W][feed_idx % W];
        end
        disp_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic model_reset();
        feed_idx = 0; model_band = 0; model_col = 0; skip = 0; hs_frame = 0;
        fin = 0; eng_cnt = 0; prev_valid = 0; prev_x = 0;
        disp_q.delete();
        core_done = 1'b0;
    endtask

    initial begin
        int budget;
        rst = 1'b1; pix_valid = 1'b0; pix_L = '0; pix_R = '0;
        core_disp = '0; core_done = 1'b0; disp_ready = 1'b0;
        frames_done = 0; stop_hit = 0; col_mode = 1; rdy_pct = 100;
        model_reset();
        new_image();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_core_clr", core_clr, 0);
        check("rst_core_start", core_start, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_col_index", col_index, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;

        // frame 1: engine returns its column index; full ready on first band
        budget = 0;
        while (frames_done == 0 && budget < 60000) begin
            step();
            budget++;
            if (model_band >= 1) begin
                rdy_pct  = 70;
                col_mode = 0;
            end
        end
        check("frame1_timeout", frames_done, 1);

        // frame 2: stop in WAIT at band 1, column 5, then reset
        budget = 0;
        while (!stop_hit && budget < 20000) begin
            step();
            budget++;
        end
        check("wait_reached", stop_hit, 1);
        rst = 1'b1;
        #1;
        check("abort_pix_ready", pix_ready, 0);
        check("abort_core_clr", core_clr, 0);
        check("abort_core_start", core_start, 0);
        check("abort_disp_valid", disp_valid, 0);
        check("abort_disp_data", disp_data, 0);
        check("abort_col_index", col_index, 0);
        check("abort_frame_done", frame_done, 0);
        check("abort_band_L_zero", band_L == '0, 1);
        check("abort_band_R_zero", band_R == '0, 1);
        model_reset();
        new_image();
        repeat (3) step();
        rst = 1'b0;

        // frame 3: restart from pixel (0,0); needs WIN full rows again
        budget = 0;
        while (model_band < 2 && budget < 20000) begin
            step();
            budget++;
        end
        check("frame3_progress", model_band >= 2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
